alu_exec_sequencer: RTL and testbench

//  Execute-stage controller that sequences one ALU operation per request, keyed by the 4-bit ALU_Control code.
//  Add/Sub/Or/And/compares complete in 1 cycle; Mult and Div run iteratively over WIDTH cycles in a shared

---
 rtl/alu_exec_sequencer_pkg.sv | 32 +++
 rtl/alu_exec_sequencer_if.sv | 30 +++
 rtl/alu_exec_sequencer_muldiv_iter.sv | 73 +++++++
 rtl/alu_exec_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared ALU_Control op codes, controller state encoding and op classification helper.
// The ALU control decoder imports the same package so both sides agree on the codes.
package alu_pkg;

  localparam logic [3:0] ALU_DIV     = 4'b0000;
  localparam logic [3:0] ALU_MULT    = 4'b0001;
  localparam logic [3:0] ALU_SUB     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_OR      = 4'b0100;
  localparam logic [3:0] ALU_AND     = 4'b0101;
  localparam logic [3:0] ALU_LT      = 4'b0110;
  localparam logic [3:0] ALU_LET     = 4'b0111;
  localparam logic [3:0] ALU_GT      = 4'b1000;
  localparam logic [3:0] ALU_GET     = 4'b1001;
  localparam logic [3:0] ALU_COMP    = 4'b1010;
  localparam logic [3:0] ALU_NEQ     = 4'b1011;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL_RUN,
    ST_DIV_RUN,
    ST_FINISH
  } alu_state_e;

  // Divide by zero takes the single-cycle path so it can report immediately.
  function automatic logic needs_iter(input logic [3:0] code, input logic divisorZero);
    return (code == ALU_MULT) || ((code == ALU_DIV) && !divisorZero);
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// Request/response bundle between the pipeline and the execute-stage sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface alu_exec_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [3:0]       ALU_Control;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_Hi;
  logic             Zero;
  logic             Illegal;
  logic             Div_By_Zero;

  modport master (
    output Start, ALU_Control, A, B, Flush,
    input  Busy, Done, Result, Result_Hi, Zero, Illegal, Div_By_Zero
  );

  modport slave (
    input  Start, ALU_Control, A, B, Flush,
    output Busy, Done, Result, Result_Hi, Zero, Illegal, Div_By_Zero
  );

endinterface

// File: rtl/alu_exec_sequencer_muldiv_iter.sv
// Shared iterative datapath: unsigned shift-add multiply and restoring divide,
// one bit per Step over WIDTH steps, results left in {Hi, Lo}.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic             Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Step,
  output logic             Last,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;

  // Multiply keeps the multiplier in Lo and shifts product bits in from the top;
  // divide shifts dividend bits out of Lo into the partial remainder in Hi.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    divShift = {hi_q, lo_q[WIDTH-1]};
    divFits  = (divShift >= {1'b0, opnd_q});
    if (mode_q) begin
      hi_d = divFits ? (divShift[WIDTH-1:0] - opnd_q) : divShift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], divFits};
    end else begin
      hi_d = mulSum[WIDTH:1];
      lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (Load) begin
      hi_q   <= '0;
      lo_q   <= Mode ? A : B;
      opnd_q <= Mode ? B : A;
      mode_q <= Mode;
      cnt_q  <= CW'(WIDTH - 1);
    end else if (Step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign Last = (cnt_q == '0);
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage controller: one ALU op per accepted Start, single-cycle ops done here,
// Mult/Div handed to muldiv_iter. Busy stalls the pipeline while an iterative op runs.
module alu_exec_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  alu_exec_sequencer_if.slave bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] resultHi_q, resultHi_d;
  logic             illegal_q, illegal_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] execRes, execHi;
  logic             execIll, execDbz;
  logic             isEq, isLt;
  logic             iterOp, accept;
  logic             mdLoad, mdStep, mdLast;
  logic [WIDTH-1:0] mdHi, mdLo;
  logic [WIDTH-1:0] resultOut;

  // Single-cycle results straight from the request operands, registered on accept.
  always_comb begin
    execRes = '0;
    execHi  = '0;
    execIll = 1'b0;
    execDbz = 1'b0;
    isEq    = (bus.A == bus.B);
    if (SIGNED_CMP) begin
      isLt = ($signed(bus.A) < $signed(bus.B));
    end else begin
      isLt = (bus.A < bus.B);
    end
    case (bus.ALU_Control)
      ALU_DIV: begin
        if (bus.B == '0) begin
          execRes = '1;
          execHi  = bus.A;
          execDbz = 1'b1;
        end
      end
      ALU_MULT:    execRes = '0;
      ALU_SUB:     execRes = bus.A - bus.B;
      ALU_ADD:     execRes = bus.A + bus.B;
      ALU_OR:      execRes = bus.A | bus.B;
      ALU_AND:     execRes = bus.A & bus.B;
      ALU_LT:      execRes = WIDTH'(isLt);
      ALU_LET:     execRes = WIDTH'(isLt | isEq);
      ALU_GT:      execRes = WIDTH'(!isLt && !isEq);
      ALU_GET:     execRes = WIDTH'(!isLt);
      ALU_COMP:    execRes = WIDTH'(isEq);
      ALU_NEQ:     execRes = WIDTH'(!isEq);
      ALU_INVALID: execIll = 1'b1;
      default:     execIll = 1'b1;
    endcase
  end

  assign iterOp = needs_iter(bus.ALU_Control, bus.B == '0);

  // IDLE, EXEC and FINISH all accept a new request, giving back-to-back issue
  // in the Done cycle; FINISH also commits the iterative result to the hold registers.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    resultHi_d = resultHi_q;
    illegal_d  = illegal_q;
    dbz_d      = dbz_q;
    accept     = 1'b0;
    case (state_q)
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (bus.Flush) begin
          state_d = ST_IDLE;
        end else if (mdLast) begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        if (state_q == ST_FINISH) begin
          result_d   = mdLo;
          resultHi_d = mdHi;
        end
        state_d = ST_IDLE;
        if (bus.Start && !bus.Flush) begin
          accept    = 1'b1;
          illegal_d = execIll;
          dbz_d     = execDbz;
          if (iterOp) begin
            state_d = (bus.ALU_Control == ALU_MULT) ? ST_MUL_RUN : ST_DIV_RUN;
          end else begin
            state_d    = ST_EXEC;
            result_d   = execRes;
            resultHi_d = execHi;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      resultHi_q <= '0;
      illegal_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      resultHi_q <= resultHi_d;
      illegal_q  <= illegal_d;
      dbz_q      <= dbz_d;
    end
  end

  assign mdLoad = accept && iterOp;
  assign mdStep = ((state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN)) && !bus.Flush;

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Load  (mdLoad),
    .Mode  (bus.ALU_Control == ALU_DIV),
    .A     (bus.A),
    .B     (bus.B),
    .Step  (mdStep),
    .Last  (mdLast),
    .Hi    (mdHi),
    .Lo    (mdLo)
  );

  // During FINISH the datapath is shown directly; the hold registers catch it on the same edge.
  assign resultOut       = (state_q == ST_FINISH) ? mdLo : result_q;
  assign bus.Result      = resultOut;
  assign bus.Result_Hi   = (state_q == ST_FINISH) ? mdHi : resultHi_q;
  assign bus.Zero        = (resultOut == '0);
  assign bus.Busy        = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
  assign bus.Done        = (state_q == ST_EXEC) || (state_q == ST_FINISH);
  assign bus.Illegal     = (state_q == ST_EXEC) && illegal_q;
  assign bus.Div_By_Zero = (state_q == ST_EXEC) && dbz_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a cycle-level reference model of the
// request/response behaviour and literal checks pinning latency and key results.
module tb_alu_exec_sequencer;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_exec_sequencer_if #(.WIDTH(WIDTH)) bus();

  alu_exec_sequencer #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (1'b1)
  ) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int vecCount  = 0;
  int missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic straight from the op-code table.
  function automatic void modelOp(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic ill, output logic dbz, output logic iter);
    logic [63:0] p;
    r = '0; h = '0; ill = 1'b0; dbz = 1'b0; iter = 1'b0;
    p = 64'(a) * 64'(b);
    case (code)
      4'd0: begin
        if (b == 0) begin r = 32'hFFFF_FFFF; h = a; dbz = 1'b1; end
        else begin r = a / b; h = a % b; iter = 1'b1; end
      end
      4'd1:  begin r = p[31:0]; h = p[63:32]; iter = 1'b1; end
      4'd2:  r = a - b;
      4'd3:  r = a + b;
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd6:  r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = ($signed(a) >  $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (a == b) ? 32'd1 : 32'd0;
      4'd11: r = (a != b) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
  endfunction

  logic        mBusy, mDone, mIll, mDbz;
  logic [31:0] mRes, mHi, pRes, pHi;
  int          runLeft;
  logic [31:0] tr, th;
  logic        ti, td, tt;

  task automatic resetModel();
    mBusy = 1'b0; mDone = 1'b0; mIll = 1'b0; mDbz = 1'b0;
    mRes = '0; mHi = '0; pRes = '0; pHi = '0; runLeft = 0;
  endtask

  // Model advances on each clock edge from the inputs alone.
  initial begin
    resetModel();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        resetModel();
      end else begin
        mDone = 1'b0; mIll = 1'b0; mDbz = 1'b0;
        if (mBusy) begin
          if (bus.Flush) begin
            mBusy = 1'b0;
          end else begin
            runLeft--;
            if (runLeft == 0) begin
              mBusy = 1'b0; mDone = 1'b1; mRes = pRes; mHi = pHi;
            end
          end
        end else if (bus.Start && !bus.Flush) begin
          modelOp(bus.ALU_Control, bus.A, bus.B, tr, th, ti, td, tt);
          if (tt) begin
            mBusy = 1'b1; runLeft = WIDTH; pRes = tr; pHi = th;
          end else begin
            mDone = 1'b1; mRes = tr; mHi = th; mIll = ti; mDbz = td;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("Busy", 32'(bus.Busy), 32'(mBusy));
      checkOutput("Done", 32'(bus.Done), 32'(mDone));
      checkOutput("Result", bus.Result, mRes);
      checkOutput("Result_Hi", bus.Result_Hi, mHi);
      checkOutput("Zero", 32'(bus.Zero), 32'(mRes == 0));
      checkOutput("Illegal", 32'(bus.Illegal), 32'(mIll));
      checkOutput("Div_By_Zero", 32'(bus.Div_By_Zero), 32'(mDbz));
    end
  end

  task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.ALU_Control = code;
    bus.A           = a;
    bus.B           = b;
    bus.Start       = 1'b1;
    @(negedge clk);
    bus.Start       = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 1;
    while (bus.Done !== 1'b1 && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string name, input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input int expLat, input logic [31:0] expRes, input logic [31:0] expHi,
                       input logic expIll, input logic expDbz);
    int lat;
    applyStimulus(code, a, b);
    waitDone(lat);
    checkOutput({name, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({name, ".result"}, bus.Result, expRes);
    checkOutput({name, ".resultHi"}, bus.Result_Hi, expHi);
    checkOutput({name, ".zero"}, 32'(bus.Zero), 32'(expRes == 0));
    checkOutput({name, ".illegal"}, 32'(bus.Illegal), 32'(expIll));
    checkOutput({name, ".divByZero"}, 32'(bus.Div_By_Zero), 32'(expDbz));
    checkOutput({name, ".modelResult"}, mRes, expRes);
    checkOutput({name, ".modelResultHi"}, mHi, expHi);
  endtask

  initial begin
    int lat;
    int doneSeen;
    bus.Start = 1'b0; bus.Flush = 1'b0; bus.ALU_Control = '0; bus.A = '0; bus.B = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 32'(bus.Busy), 32'd0);
    checkOutput("reset.done", 32'(bus.Done), 32'd0);
    checkOutput("reset.result", bus.Result, 32'd0);
    checkOutput("reset.zero", 32'(bus.Zero), 32'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a multiply, then a plain add
    applyStimulus(4'b0001, 32'd5, 32'd7);
    repeat (4) @(negedge clk);
    checkOutput("midMul.busy", 32'(bus.Busy), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstMul.busy", 32'(bus.Busy), 32'd0);
    checkOutput("rstMul.result", bus.Result, 32'd0);
    checkOutput("rstMul.resultHi", bus.Result_Hi, 32'd0);
    checkOutput("rstMul.zero", 32'(bus.Zero), 32'd1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    runOp("add2p3", 4'b0011, 32'd2, 32'd3, 1, 32'd5, 32'd0, 1'b0, 1'b0);

    runOp("addWrap", 4'b0011, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'd0, 1'b0, 1'b0);
    runOp("sub3m5", 4'b0010, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0);
    runOp("ltSigned", 4'b0110, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 32'd0, 1'b0, 1'b0);
    runOp("or", 4'b0100, 32'h0000_00F0, 32'h0000_000F, 1, 32'h0000_00FF, 32'd0, 1'b0, 1'b0);
    runOp("and", 4'b0101, 32'h0000_00FF, 32'h0000_003C, 1, 32'h0000_003C, 32'd0, 1'b0, 1'b0);
    runOp("letEq", 4'b0111, 32'd5, 32'd5, 1, 32'd1, 32'd0, 1'b0, 1'b0);
    runOp("gtSigned", 4'b1000, 32'd2, 32'hFFFF_FFFD, 1, 32'd1, 32'd0, 1'b0, 1'b0);
    runOp("getEq", 4'b1001, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'd1, 32'd0, 1'b0, 1'b0);
    runOp("compNe", 4'b1010, 32'd7, 32'd8, 1, 32'd0, 32'd0, 1'b0, 1'b0);
    runOp("neq", 4'b1011, 32'd7, 32'd8, 1, 32'd1, 32'd0, 1'b0, 1'b0);

    runOp("mulMax", 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOp("div100by7", 4'b0000, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);
    runOp("div9by0", 4'b0000, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1);

    // Ignored Start while busy, then Flush of the running divide
    applyStimulus(4'b0000, 32'd50, 32'd5);
    repeat (3) @(negedge clk);
    applyStimulus(4'b0011, 32'd1, 32'd1);
    repeat (4) @(negedge clk);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    checkOutput("flush.busy", 32'(bus.Busy), 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) doneSeen++;
    end
    checkOutput("flush.noDone", 32'(doneSeen), 32'd0);
    checkOutput("flush.resultHeld", bus.Result, 32'hFFFF_FFFF);
    checkOutput("flush.resultHiHeld", bus.Result_Hi, 32'd9);

    bus.Flush = 1'b1;
    applyStimulus(4'b0011, 32'd4, 32'd4);
    bus.Flush = 1'b0;
    doneSeen = 0;
    repeat (3) begin
      if (bus.Done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("flushStart.noDone", 32'(doneSeen), 32'd0);
    checkOutput("flushStart.resultHeld", bus.Result, 32'hFFFF_FFFF);

    runOp("illegal1111", 4'b1111, 32'd3, 32'd4, 1, 32'd0, 32'd0, 1'b1, 1'b0);
    runOp("illegal1100", 4'b1100, 32'd3, 32'd4, 1, 32'd0, 32'd0, 1'b1, 1'b0);

    // New request issued in the Done cycle of a multiply
    applyStimulus(4'b0001, 32'd3, 32'd4);
    waitDone(lat);
    checkOutput("b2bMul.latency", 32'(lat), 32'd33);
    checkOutput("b2bMul.result", bus.Result, 32'd12);
    checkOutput("b2bMul.busy", 32'(bus.Busy), 32'd0);
    applyStimulus(4'b0011, 32'd10, 32'd20);
    checkOutput("b2bAdd.done", 32'(bus.Done), 32'd1);
    checkOutput("b2bAdd.result", bus.Result, 32'd30);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
